// File: rtl/fetch_group_decode.sv
// Fetch/pre-decode stage: fetches FETCH_W 16-bit instructions per cycle, holds them in one
// decode register and tags intra-group operand dependencies with ROB owner indices.
//   state  | meaning
//   RUN    | fetching one group per accepted handshake
//   HALTED | halt group captured; fetch frozen until redirect or reset
module fetch_group_decode #(
  parameter int FETCH_W   = 4,
  parameter int PC_W      = 16,
  parameter int ROB_IDX_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          is_jump,
  input  logic [PC_W-1:0]               jump_target,
  output logic [FETCH_W*PC_W-1:0]       icache_pc,
  input  logic [FETCH_W*16-1:0]         icache_instr,
  input  logic [ROB_IDX_W-1:0]          rob_alloc_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FETCH_W-1:0]            out_slot_valid,
  output logic [FETCH_W*PC_W-1:0]       out_pc,
  output logic [FETCH_W*4-1:0]          out_opcode,
  output logic [FETCH_W*4-1:0]          out_rt,
  output logic [FETCH_W*4-1:0]          out_ra,
  output logic [FETCH_W*4-1:0]          out_rb,
  output logic [FETCH_W-1:0]            out_a_dep,
  output logic [FETCH_W-1:0]            out_b_dep,
  output logic [FETCH_W*ROB_IDX_W-1:0]  out_a_owner,
  output logic [FETCH_W*ROB_IDX_W-1:0]  out_b_owner,
  output logic                          halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} mode_e;

  function automatic logic writes_rt(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h1) || (op == 4'h2) ||
           (op == 4'h4) || (op == 4'h5) || (op == 4'h6);
  endfunction

  function automatic logic uses_rb(input logic [3:0] op);
    return (op == 4'h0) || (op == 4'h1);
  endfunction

  mode_e                        mode_q, mode_d;
  logic [PC_W-1:0]              fetch_pc_q, fetch_pc_d;
  logic                         d_valid_q, d_valid_d;
  logic [FETCH_W-1:0][15:0]     d_instr_q, d_instr_d;
  logic [FETCH_W-1:0][PC_W-1:0] d_pc_q, d_pc_d;
  logic [FETCH_W-1:0]           d_slot_valid_q, d_slot_valid_d;

  logic                         capture;
  logic                         hit_halt;
  logic [FETCH_W-1:0]           fetch_slot_valid;
  logic [FETCH_W-1:0][PC_W-1:0] fetch_pc_vec;
  logic [FETCH_W-1:0]           slot_v;

  assign out_valid = d_valid_q & ~is_jump;
  assign capture   = (mode_q == RUN) & ~is_jump & (~d_valid_q | (out_valid & out_ready));
  assign slot_v    = d_slot_valid_q & {FETCH_W{d_valid_q}};

  // Slots after the first halt are dropped; the halt itself stays valid.
  always_comb begin
    hit_halt         = 1'b0;
    fetch_slot_valid = '0;
    fetch_pc_vec     = '0;
    icache_pc        = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      fetch_pc_vec[k]               = fetch_pc_q + PC_W'(2 * k);
      icache_pc[k*PC_W +: PC_W]     = fetch_pc_vec[k];
      fetch_slot_valid[k]           = ~hit_halt;
      if (icache_instr[k*16+12 +: 4] == 4'hF) hit_halt = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) mode_q <= RUN;
    else        mode_q <= mode_d;
  end

  // FSM: next state
  always_comb begin
    mode_d = mode_q;
    if (is_jump)                   mode_d = RUN;
    else if (capture && hit_halt)  mode_d = HALTED;
  end

  // FSM: outputs
  always_comb begin
    halted = (mode_q == HALTED);
  end

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    d_valid_d      = d_valid_q;
    d_instr_d      = d_instr_q;
    d_pc_d         = d_pc_q;
    d_slot_valid_d = d_slot_valid_q;
    if (is_jump) begin
      fetch_pc_d = jump_target;
      d_valid_d  = 1'b0;
    end else if (capture) begin
      fetch_pc_d     = fetch_pc_q + PC_W'(2 * FETCH_W);
      d_valid_d      = 1'b1;
      d_pc_d         = fetch_pc_vec;
      d_slot_valid_d = fetch_slot_valid;
      for (int k = 0; k < FETCH_W; k++) d_instr_d[k] = icache_instr[k*16 +: 16];
    end else if (out_valid && out_ready) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q     <= '0;
      d_valid_q      <= 1'b0;
      d_instr_q      <= '0;
      d_pc_q         <= '0;
      d_slot_valid_q <= '0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      d_valid_q      <= d_valid_d;
      d_instr_q      <= d_instr_d;
      d_pc_q         <= d_pc_d;
      d_slot_valid_q <= d_slot_valid_d;
    end
  end

  always_comb begin
    out_slot_valid = slot_v;
    out_pc         = '0;
    out_opcode     = '0;
    out_rt         = '0;
    out_ra         = '0;
    out_rb         = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      out_pc[k*PC_W +: PC_W] = d_pc_q[k];
      out_opcode[k*4 +: 4]   = d_instr_q[k][15:12];
      out_rt[k*4 +: 4]       = d_instr_q[k][11:8];
      out_ra[k*4 +: 4]       = d_instr_q[k][7:4];
      out_rb[k*4 +: 4]       = d_instr_q[k][3:0];
    end
  end

  // Ascending scan so the youngest older writer wins.
  always_comb begin
    out_a_dep   = '0;
    out_b_dep   = '0;
    out_a_owner = '0;
    out_b_owner = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if ((i < k) && slot_v[k] && slot_v[i] && writes_rt(d_instr_q[i][15:12])) begin
          if (writes_rt(d_instr_q[k][15:12]) && (d_instr_q[i][11:8] == d_instr_q[k][7:4])) begin
            out_a_dep[k]                          = 1'b1;
            out_a_owner[k*ROB_IDX_W +: ROB_IDX_W] = rob_alloc_idx + ROB_IDX_W'(i);
          end
          if (uses_rb(d_instr_q[k][15:12]) && (d_instr_q[i][11:8] == d_instr_q[k][3:0])) begin
            out_b_dep[k]                          = 1'b1;
            out_b_owner[k*ROB_IDX_W +: ROB_IDX_W] = rob_alloc_idx + ROB_IDX_W'(i);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_group_decode.sv
// Directed bench for fetch_group_decode with FETCH_W=4, PC_W=16, ROB_IDX_W=4 and a
// combinational instruction memory answering icache_pc.
module tb_fetch_group_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_jump;
  logic [15:0] jump_target;
  logic [63:0] icache_pc;
  logic [63:0] icache_instr;
  logic [3:0]  rob_alloc_idx;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_slot_valid;
  logic [63:0] out_pc;
  logic [15:0] out_opcode, out_rt, out_ra, out_rb;
  logic [3:0]  out_a_dep, out_b_dep;
  logic [15:0] out_a_owner, out_b_owner;
  logic        halted;

  logic [15:0] imem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_group_decode #(.FETCH_W(4), .PC_W(16), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .is_jump(is_jump), .jump_target(jump_target),
    .icache_pc(icache_pc), .icache_instr(icache_instr), .rob_alloc_idx(rob_alloc_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_slot_valid(out_slot_valid),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_rt(out_rt), .out_ra(out_ra),
    .out_rb(out_rb), .out_a_dep(out_a_dep), .out_b_dep(out_b_dep),
    .out_a_owner(out_a_owner), .out_b_owner(out_b_owner), .halted(halted)
  );

  always_comb begin
    icache_instr = '0;
    for (int k = 0; k < 4; k++) icache_instr[k*16 +: 16] = imem[icache_pc[k*16+1 +: 8]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'h7000 | 16'(i);
    imem[4] = 16'h0123; imem[5] = 16'h1411; imem[6] = 16'h2140; imem[7] = 16'h0514;
    imem[8'h24] = 16'h0123; imem[8'h25] = 16'hF000; imem[8'h26] = 16'h0511;
    rst_n = 1'b0; is_jump = 1'b0; jump_target = '0; out_ready = 1'b1; rob_alloc_idx = '0;

    @(negedge clk);
    tick();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_slot_valid", out_slot_valid, 0);
    chk("rst_deps", {out_a_dep, out_b_dep, out_a_owner, out_b_owner}, 0);
    chk("rst_icache_pc", icache_pc, 64'h0006_0004_0002_0000);

    rst_n = 1'b1;
    tick(); #1;
    chk("g0_valid", out_valid, 1);
    chk("g0_pc", out_pc, 64'h0006_0004_0002_0000);
    chk("g0_slot_valid", out_slot_valid, 4'hF);
    chk("g0_icache_pc", icache_pc, 64'h000E_000C_000A_0008);
    chk("g0_deps", {out_a_dep, out_b_dep}, 0);

    rob_alloc_idx = 4'd14;
    tick(); #1;
    chk("dep_pc", out_pc, 64'h000E_000C_000A_0008);
    chk("dep_opcode", out_opcode, 16'h0210);
    chk("dep_rt_ra_rb", {out_rt, out_ra, out_rb}, 48'h5141_1412_4013);
    chk("dep_a_dep", out_a_dep, 4'b1110);
    chk("dep_b_dep", out_b_dep, 4'b1010);
    chk("dep_a_owner", out_a_owner, 16'h0FE0);
    chk("dep_b_owner", out_b_owner, 16'hF0E0);
    rob_alloc_idx = 4'd2; #1;
    chk("dep_a_owner_idx2", out_a_owner, 16'h4320);
    chk("dep_b_owner_idx2", out_b_owner, 16'h3020);

    out_ready = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 64'h000E_000C_000A_0008);
      chk("stall_icache_pc", icache_pc, 64'h0016_0014_0012_0010);
    end
    out_ready = 1'b1;
    tick(); #1;
    chk("after_stall_pc", out_pc, 64'h0016_0014_0012_0010);
    chk("after_stall_icache_pc", icache_pc, 64'h001E_001C_001A_0018);

    is_jump = 1'b1; jump_target = 16'h0040; #1;
    chk("jump_valid_low", out_valid, 0);
    tick();
    is_jump = 1'b0; #1;
    chk("jump_c1_valid", out_valid, 0);
    chk("jump_c1_icache_pc", icache_pc, 64'h0046_0044_0042_0040);
    tick(); #1;
    chk("jump_c2_valid", out_valid, 1);
    chk("jump_c2_pc", out_pc, 64'h0046_0044_0042_0040);

    tick(); #1;
    chk("halt_slot_valid", out_slot_valid, 4'b0011);
    chk("halt_halted", halted, 1);
    chk("halt_valid", out_valid, 1);
    chk("halt_masked_dep", out_a_dep, 0);
    tick(); #1;
    chk("halt_drained", out_valid, 0);
    tick(); #1;
    chk("halt_no_fetch", out_valid, 0);
    chk("halt_still", halted, 1);
    chk("halt_icache_pc", icache_pc, 64'h0056_0054_0052_0050);

    is_jump = 1'b1; jump_target = 16'hFFFC;
    tick();
    is_jump = 1'b0; #1;
    chk("resume_halted", halted, 0);
    chk("wrap_icache_pc", icache_pc, 64'h0002_0000_FFFE_FFFC);
    tick(); #1;
    chk("wrap_valid", out_valid, 1);
    chk("wrap_pc", out_pc, 64'h0002_0000_FFFE_FFFC);

    out_ready = 1'b0;
    tick(); #1;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0; is_jump = 1'b1; jump_target = 16'h0040;
    tick(); #1;
    chk("midrst_slot_valid", out_slot_valid, 0);
    chk("midrst_icache_pc0", icache_pc[15:0], 0);
    is_jump = 1'b0; rst_n = 1'b1; out_ready = 1'b1; #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_icache_pc", icache_pc, 64'h0006_0004_0002_0000);
    tick(); #1;
    chk("midrst_refetch_pc", out_pc, 64'h0006_0004_0002_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_group_decode.md
# fetch_group_decode

Parametrised fetch/pre-decode stage that fetches a group of FETCH_W consecutive 16-bit instructions per cycle from the instruction cache. It holds each group in one decode register and hands it to the instruction buffer over a valid/ready handshake. On the way it marks intra-group register dependencies with ROB owner tags. It sits between the branch unit / icache and the instruction buffer, and adds back-pressure, redirect flush, halt detection and ROB index wrap-around.

## Interface
Parameters:
- FETCH_W, 4: instructions per group, ≥1.
- PC_W, 16: PC width; instructions are 2 bytes.
- ROB_IDX_W, 4: ROB tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- is_jump  in  1  redirect request from the branch unit.
- jump_target  in  PC_W  redirect PC.
- icache_pc  out  FETCH_W*PC_W  slot k = fetch_pc + 2k, modulo 2^PC_W.
- icache_instr  in  FETCH_W*16  combinational icache return for icache_pc, same cycle.
- rob_alloc_idx  in  ROB_IDX_W  ROB index that slot 0 of the emitted group will receive.
- out_valid  out  1  group available.
- out_ready  in  1  instruction buffer accepts the group.
- out_slot_valid  out  FETCH_W  per-slot valid mask.
- out_pc  out  FETCH_W*PC_W  per-slot PC.
- out_opcode, out_rt, out_ra, out_rb  out  FETCH_W*4 each  fields [15:12], [11:8], [7:4], [3:0].
- out_a_dep, out_b_dep  out  FETCH_W each  operand produced by an older slot of the same group.
- out_a_owner, out_b_owner  out  FETCH_W*ROB_IDX_W each  ROB tag of that producer.
- halted  out  1  fetch stopped on halt.

## Operation
- State: fetch_pc (PC_W), mode ∈ {RUN, HALTED}, decode register D = {d_valid, instr[FETCH_W], pc[FETCH_W], slot_valid mask}.
- Decode classes:
  - writes_rt: opcode ∈ {0,1,2,4,5,6}.
  - uses_ra: same set as writes_rt.
  - uses_rb: opcode ∈ {0,1}.
  - halt: opcode 4'hF.
- Capture condition: mode=RUN, ~is_jump, and (~d_valid or (out_valid & out_ready)).
- On capture:
  - D ← icache data.
  - fetch_pc ← fetch_pc + 2*FETCH_W, with wrap.
  - slot_valid = all ones, unless some slot h holds halt: then slots 0..h are valid, slots >h invalid, and mode ← HALTED.
- Slot 0 is never invalid.
- out_valid = d_valid & ~is_jump. On out_valid & out_ready without capture: d_valid ← 0.
- Redirect (is_jump=1):
  - d_valid ← 0.
  - fetch_pc ← jump_target.
  - mode ← RUN.
  - No capture and no handshake transfer that cycle.
  - Redirect has priority over every other event.
- Dependency (combinational on D, rob_alloc_idx). For slot k with valid source s (ra if uses_ra, rb if uses_rb):
  - Find the youngest i<k with slot_valid[i], writes_rt[i] and rt[i]==s.
  - If found: dep=1, owner = rob_alloc_idx + i, modulo 2^ROB_IDX_W (wraps).
  - Else: dep=0, owner=0.
  - Slot 0 always dep=0.
  - Invalid slots: dep=0, owner=0.
- Output fields of invalid slots carry D contents; the consumer ignores them.
- halted = (mode==HALTED).

## Timing
- Reset (rst_n=0 at posedge):
  - fetch_pc=0, mode=RUN, d_valid=0.
  - out_valid=0, halted=0, out_slot_valid=0, all dep=0, owners=0.
- Reset overrides is_jump and any in-flight group.
- Fetch-to-output latency: 1 cycle. A group fetched in cycle c is presented in c+1.
- Throughput: 1 group/cycle while out_ready=1.
- Stall: with out_ready=0, D and all outputs are held stable, and fetch_pc is held.
- Redirect in cycle c: out_valid=0 in c; the target group is fetched in c+1 and presented in c+2.
- Halt captured in cycle c: halted=1 from c+1. The halt group is still emitted. No further capture until redirect or reset.
- The owner/dep outputs follow rob_alloc_idx combinationally and need not be stable while out_ready=0.

## Test plan
- Reset, then straight-line code, out_ready=1, FETCH_W=4:
  - icache_pc = {0,2,4,6}, then {8,A,C,E}.
  - out_valid first high 1 cycle after reset release.
  - out_pc = {0,2,4,6}, out_slot_valid=4'b1111.
- Dependencies, group {add r1,r2,r3; sub r4,r1,r1; op2 r1,r4; add r5,r1,r4} with rob_alloc_idx=14, ROB_IDX_W=4:
  - slot1: a_dep=b_dep=1, owner=14.
  - slot2: a_dep=1, owner=15; b_dep=0.
  - slot3: a_owner=0 (wrap), b_owner=15, both dep=1.
- Back-pressure: out_ready=0 for 3 cycles, then 1:
  - outputs and icache_pc frozen during the stall.
  - no group lost or duplicated.
  - next group follows on the cycle after acceptance.
- Redirect, is_jump=1 with jump_target=0x40 while out_valid=1 and out_ready=1:
  - out_valid=0 that cycle.
  - next icache_pc={40,42,44,46}.
  - that group is presented 2 cycles after the redirect.
- Halt in slot 1:
  - out_slot_valid=4'b0011 and halted=1 next cycle.
  - no more out_valid groups after acceptance.
  - a later is_jump clears halted and resumes fetch.
- Reset asserted mid-stall with d_valid=1:
  - out_valid=0 and icache_pc slot 0 = 0 next cycle.
  - is_jump asserted in the same cycle is ignored.
